// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one free-running 16-bit event counter among NREQ
// requesters. One round-robin measurement window at a time; the owner's events
// drive cnt_up, and the window result is count_in(end) - count_in(start) mod 2^16.
// Build option: define CNT_ARB_TIMEOUT_EN to force-close windows after MAX_GRANT
// GRANT cycles and mask the timed-out requester until its req drops.
module counter_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned CNT_LAT   = 3,
  parameter int unsigned MAX_GRANT = 1024
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] ev,
  output logic [NREQ-1:0] gnt,
  output logic            cnt_up,
  input  logic [15:0]     count_in,
  output logic            busy,
  output logic            res_valid,
  output logic [IDW-1:0]  res_id,
  output logic [15:0]     res_delta,
  output logic            res_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, REPORT} state_t;

  localparam int unsigned DW = $clog2(CNT_LAT + 1) + 1;

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || MAX_GRANT < 1) begin : g_param_check
    $error("counter_arbiter: illegal parameter set");
  end

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, own_id, pick_id, arb_cand;
  int unsigned     arb_idx;
  logic            pick_ok, start_win, close_win, close_to, timeout_hit, win_to;
  logic [NREQ-1:0] to_mask, elig;
  logic [15:0]     base;
  logic [DW-1:0]   drain_cnt;

  assign elig = req & ~to_mask;
  assign busy = (state != IDLE);

  // Round-robin search from rr_ptr upward with wrap; first eligible requester wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_id  = '0;
    arb_idx  = 0;
    arb_cand = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_idx  = (32'(rr_ptr) + i) % NREQ;
      arb_cand = IDW'(arb_idx);
      if (!pick_ok && elig[arb_cand]) begin
        pick_ok = 1'b1;
        pick_id = arb_cand;
      end
    end
  end

  // Next-state logic and window open/close strobes.
  always_comb begin
    state_nxt = state;
    start_win = 1'b0;
    close_win = 1'b0;
    close_to  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = GRANT;
          start_win = 1'b1;
        end
      end
      GRANT: begin
        if (!req[own_id]) begin
          state_nxt = DRAIN;
          close_win = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = DRAIN;
          close_win = 1'b1;
          close_to  = 1'b1;
        end
      end
      DRAIN:   if (drain_cnt == DW'(CNT_LAT)) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Window bookkeeping, gated count enable and held result registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      gnt         <= '0;
      cnt_up      <= 1'b0;
      own_id      <= '0;
      rr_ptr      <= '0;
      base        <= '0;
      win_to      <= 1'b0;
      drain_cnt   <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_delta   <= '0;
      res_timeout <= 1'b0;
    end else begin
      cnt_up    <= 1'b0;
      res_valid <= 1'b0;
      drain_cnt <= '0;
      if (start_win) begin
        gnt    <= NREQ'(1) << pick_id;
        own_id <= pick_id;
        base   <= count_in;
        win_to <= 1'b0;
        rr_ptr <= (32'(pick_id) == NREQ - 1) ? '0 : pick_id + 1'b1;
      end
      if (state == GRANT && !close_win) cnt_up <= ev[own_id] & req[own_id];
      if (close_win) begin
        gnt    <= '0;
        win_to <= close_to;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      if (state == REPORT) begin
        res_valid   <= 1'b1;
        res_id      <= own_id;
        res_delta   <= count_in - base;
        res_timeout <= win_to;
      end
    end
  end

`ifdef CNT_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(MAX_GRANT + 1);
  logic [TW-1:0] grant_cyc;

  assign timeout_hit = (state == GRANT) && (grant_cyc == TW'(MAX_GRANT - 1));

  // GRANT-cycle timer; timed-out owner stays masked while its req is held.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      grant_cyc <= '0;
      to_mask   <= '0;
    end else begin
      grant_cyc <= (state == GRANT) ? grant_cyc + 1'b1 : '0;
      to_mask   <= (to_mask | (close_to ? (NREQ'(1) << own_id) : '0)) & req;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_mask     = '0;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: random and directed stimulus for counter_arbiter with an
// external CNT_LAT-cycle counter model and a window-level reference model.
module tb_counter_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned CNT_LAT = 3;
`ifdef CNT_ARB_TIMEOUT_EN
  localparam int unsigned MG    = 16;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned MG    = 1024;
  localparam bit          TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nReset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] ev = '0;
  logic [NREQ-1:0] gnt;
  logic            cnt_up, busy, res_valid, res_timeout;
  logic [IDW-1:0]  res_id;
  logic [15:0]     res_delta;
  logic [15:0]     count;
  logic [CNT_LAT-2:0] pipe;

  int cmp_n = 0;
  int fail_n = 0;
  int tcyc = 0;

  typedef struct { int cyc; int id; int delta; int to; } res_t;
  res_t rq[$];
  int   gq[$];

  counter_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNT_LAT(CNT_LAT), .MAX_GRANT(MG)) dut (
    .clk(clk), .nReset(nReset), .req(req), .ev(ev), .gnt(gnt), .cnt_up(cnt_up),
    .count_in(count), .busy(busy), .res_valid(res_valid), .res_id(res_id),
    .res_delta(res_delta), .res_timeout(res_timeout)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); tcyc++; end

  // External counter: cnt_up high after edge k shows up in count after edge k+CNT_LAT.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
      pipe  <= '0;
    end else begin
      pipe  <= {pipe[CNT_LAT-3:0], cnt_up};
      count <= count + 16'(pipe[CNT_LAT-2]);
    end
  end

  function automatic logic bitof(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  // Reference model: window owner, event tally and report deadline.
  int              m_own = -1, m_rr = 0, m_gc = 0, m_cyc = 0, m_report_at = 0, m_c = 0;
  bit              m_closing = 1'b0, m_wto = 1'b0;
  int unsigned     m_events = 0;
  logic [NREQ-1:0] m_mask = '0;
  logic [NREQ-1:0] x_gnt = '0;
  logic            x_cnt_up = 1'b0, x_busy = 1'b0, x_valid = 1'b0, x_to = 1'b0;
  logic [IDW-1:0]  x_id = '0;
  logic [15:0]     x_delta = '0;

  initial forever begin
    @(posedge clk or negedge nReset);
    if (!nReset) begin
      m_own = -1; m_closing = 1'b0; m_rr = 0; m_mask = '0; m_wto = 1'b0;
      x_gnt = '0; x_cnt_up = 1'b0; x_busy = 1'b0; x_valid = 1'b0;
      x_id = '0; x_delta = '0; x_to = 1'b0;
    end else begin
      m_cyc++;
      x_valid  = 1'b0;
      x_cnt_up = 1'b0;
      if (m_own < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_rr + k) % NREQ;
          if (m_own < 0 && bitof(req & ~m_mask, m_c)) m_own = m_c;
        end
        if (m_own >= 0) begin
          x_gnt    = NREQ'(1) << m_own;
          x_busy   = 1'b1;
          m_rr     = (m_own + 1) % NREQ;
          m_events = 0;
          m_gc     = 0;
        end
      end else if (!m_closing) begin
        m_gc++;
        if (!bitof(req, m_own) || (TO_EN && m_gc == MG)) begin
          m_wto = bitof(req, m_own);
          if (m_wto) m_mask = m_mask | (NREQ'(1) << m_own);
          m_closing   = 1'b1;
          m_report_at = m_cyc + CNT_LAT + 2;
          x_gnt       = '0;
        end else begin
          x_cnt_up = bitof(ev, m_own);
          m_events += 32'(x_cnt_up);
        end
      end else if (m_cyc == m_report_at) begin
        x_valid   = 1'b1;
        x_id      = IDW'(m_own);
        x_delta   = 16'(m_events);
        x_to      = m_wto;
        x_busy    = 1'b0;
        m_own     = -1;
        m_closing = 1'b0;
      end
      m_mask = m_mask & req;
    end
  end

  // Per-cycle comparison against the model; logs results and grant order.
  logic [NREQ-1:0] prev_gnt = '0;
  initial forever begin
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(x_gnt));
    chk("cnt_up", 32'(cnt_up), 32'(x_cnt_up));
    chk("busy", 32'(busy), 32'(x_busy));
    chk("res_valid", 32'(res_valid), 32'(x_valid));
    chk("res_id", 32'(res_id), 32'(x_id));
    chk("res_delta", 32'(res_delta), 32'(x_delta));
    chk("res_timeout", 32'(res_timeout), 32'(x_to));
    if (res_valid === 1'b1) rq.push_back('{tcyc, int'(res_id), int'(res_delta), int'(res_timeout)});
    if (gnt != '0 && prev_gnt == '0)
      for (int b = 0; b < NREQ; b++) if (bitof(gnt, b)) gq.push_back(b);
    prev_gnt = gnt;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic expect_result(input string nm, input int id, input int delta, input int to,
                               input int at_cyc);
    res_t r;
    int   n = 0;
    while (rq.size() == 0 && n < 60) begin tick(1); n++; end
    chk({nm, "_seen"}, 32'(rq.size() != 0), 32'd1);
    if (rq.size() != 0) begin
      r = rq.pop_front();
      chk({nm, "_id"}, r.id, id);
      chk({nm, "_delta"}, r.delta, delta);
      chk({nm, "_timeout"}, r.to, to);
      if (at_cyc >= 0) chk({nm, "_latency"}, r.cyc, at_cyc);
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0; tick(2); nReset = 1'b1; tick(1);
  endtask

  int fall_cyc;

  initial begin
    tick(3);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt_up", 32'(cnt_up), 32'd0);
    chk("rst_delta", 32'(res_delta), 32'd0);
    nReset = 1'b1;
    tick(2);

    // req0 for 10 cycles, ev0 on 7 of the GRANT cycles
    req = 4'b0001; tick(1);
    ev = 4'b0001; tick(7);
    ev = 4'b0000; tick(2);
    req = 4'b0000; fall_cyc = tcyc;
    expect_result("win7", 0, 7, 0, fall_cyc + CNT_LAT + 3);
    tick(3);

    // req1 owns; foreign events must not count
    req = 4'b0010; tick(1);
    chk("own1_gnt", 32'(gnt), 32'b0010);
    for (int i = 0; i < 12; i++) begin
      ev = (i % 2 == 0) ? 4'b1001 : 4'b0000;
      tick(1);
      chk("own1_cnt_up", 32'(cnt_up), 32'd0);
    end
    ev = '0; req = '0;
    expect_result("foreign_ev", 1, 0, 0, -1);
    tick(3);

    // reset mid-window with events active
    req = 4'b0100; ev = 4'b0100; tick(6);
    nReset = 1'b0; #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_cnt_up", 32'(cnt_up), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick(2); req = '0; ev = '0; nReset = 1'b1;
    tick(15);
    chk("midrst_no_result", rq.size(), 0);

    // simultaneous req0/req2; just-served owner drops to lowest priority
    gq.delete();
    req = 4'b0101; tick(1);
    chk("rr_first", 32'(gnt), 32'b0001);
    tick(6); req[0] = 1'b0; tick(2); req[0] = 1'b1; tick(8);
    chk("rr_count2", gq.size(), 2);
    if (gq.size() >= 2) chk("rr_second", gq[1], 2);
    req[2] = 1'b0; tick(10);
    chk("rr_count3", gq.size(), 3);
    if (gq.size() >= 3) chk("rr_third", gq[2], 0);
    req = '0;
    expect_result("rr_r0", 0, 0, 0, -1);
    expect_result("rr_r1", 2, 0, 0, -1);
    expect_result("rr_r2", 0, 0, 0, -1);
    tick(3);

`ifndef CNT_ARB_TIMEOUT_EN
    // preload counter to 0xFFF0, then a 0x20-event window across the wrap
    do_reset();
    req = 4'b0010; tick(1);
    ev = 4'b0010; tick(16'hFFF0);
    ev = '0; req = '0;
    expect_result("preload", 1, 16'hFFF0, 0, -1);
    req = 4'b0001; tick(1);
    ev = 4'b0001; tick(32);
    ev = '0; req = '0;
    expect_result("wrap", 0, 16'h0020, 0, -1);
    tick(2);
    chk("ctr_end", 32'(count), 32'h0010);
`else
    // forced close after MAX_GRANT GRANT cycles; owner masked until req drops
    do_reset();
    gq.delete();
    req = 4'b0011; tick(1);
    chk("to_first", 32'(gnt), 32'b0001);
    tick(27); req[1] = 1'b0; tick(13);
    chk("to_count2", gq.size(), 2);
    if (gq.size() >= 2) chk("to_second", gq[1], 1);
    req[0] = 1'b0;
    expect_result("to_r0", 0, 0, 1, -1);
    expect_result("to_r1", 1, 0, 0, -1);
    tick(1); req[0] = 1'b1; tick(3);
    chk("to_count3", gq.size(), 3);
    if (gq.size() >= 3) chk("to_third", gq[2], 0);
    req = '0;
    expect_result("to_r2", 0, 0, 0, -1);
`endif

    // random traffic checked by the per-cycle model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 9) == 0) req = req ^ (NREQ'(1) << b);
      ev = NREQ'($urandom);
      if (c == 1500) nReset = 1'b0;
      if (c == 1503) nReset = 1'b1;
      tick(1);
    end
    req = '0; ev = '0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

  initial begin
    #2000000;
    fail_n++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
